// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor: state encoding,
// counter widths, saturation value and a sizing helper for the shared timer.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAIL      = 3'd5
   } state_t;

   localparam int RETRY_W = 4;
   localparam int LOSS_W  = 8;
   localparam logic [LOSS_W-1:0] LOSS_SAT = 8'hFF;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/pll_sup_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared by reset_n.
module sync_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL power-up/relock sequencer: pulses the PLL reset, qualifies lock, releases
// the output-clock domain resets one by one, retries on timeout, flags failure.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int N_DOMAINS           = 4,
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int STABLE_CYCLES       = 1024,
   parameter int STAGGER_CYCLES      = 8,
   parameter int MAX_RETRIES         = 7
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 pll_locked_i,
   input  logic                 force_relock_i,
   output logic                 pll_rst_o,
   output logic [N_DOMAINS-1:0] domain_rst_n_o,
   output logic                 ready_o,
   output logic                 lock_fail_o,
   output logic [RETRY_W-1:0]   retry_cnt_o,
   output logic [LOSS_W-1:0]    lock_loss_cnt_o,
   output state_t               state_dbg
);

   localparam int TIMER_MAX = max4(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES,
                                   N_DOMAINS * STAGGER_CYCLES);
   localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

   // The WAIT_LOCK edge that first sees locked_s=1 is already one qualifying cycle.
   localparam int STABLE_LAST = (STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0;

   localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_PULSE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] STB_LAST     = TIMER_W'(STABLE_LAST);
   localparam logic [TIMER_W-1:0] RELEASE_END  = TIMER_W'(N_DOMAINS * STAGGER_CYCLES);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

   state_t               state;
   logic [TIMER_W-1:0]   timer;
   logic [TIMER_W-1:0]   timer_nxt;
   logic [RETRY_W-1:0]   retry_nxt;
   logic                 locked_s;

   sync_2ff u_lock_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pll_locked_i),
      .q       (locked_s)
   );

   assign timer_nxt   = timer + 1'b1;
   assign retry_nxt   = retry_cnt_o + 1'b1;
   assign ready_o     = (state == RUN);
   assign lock_fail_o = (state == FAIL);
   assign state_dbg   = state;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= PLL_RST;
         timer           <= '0;
         pll_rst_o       <= 1'b1;
         domain_rst_n_o  <= '0;
         retry_cnt_o     <= '0;
         lock_loss_cnt_o <= '0;
      end else begin
         // Lock loss is counted even when a relock request wins the transition.
         if (state == RUN && !locked_s && lock_loss_cnt_o != LOSS_SAT)
            lock_loss_cnt_o <= lock_loss_cnt_o + 1'b1;

         if (force_relock_i) begin
            state          <= PLL_RST;
            timer          <= '0;
            retry_cnt_o    <= '0;
            pll_rst_o      <= 1'b1;
            domain_rst_n_o <= '0;
         end else begin
            case (state)
               PLL_RST: begin
                  if (timer == RST_LAST) begin
                     state     <= WAIT_LOCK;
                     timer     <= '0;
                     pll_rst_o <= 1'b0;
                  end else begin
                     timer <= timer_nxt;
                  end
               end
               WAIT_LOCK: begin
                  if (locked_s) begin
                     state <= STABLE;
                     timer <= '0;
                  end else if (timer == TIMEOUT_LAST) begin
                     timer       <= '0;
                     retry_cnt_o <= retry_nxt;
                     pll_rst_o   <= 1'b1;
                     state       <= (retry_nxt == RETRY_LIMIT) ? FAIL : PLL_RST;
                  end else begin
                     timer <= timer_nxt;
                  end
               end
               STABLE: begin
                  if (!locked_s) begin
                     state <= WAIT_LOCK;
                     timer <= '0;
                  end else if (timer == STB_LAST) begin
                     state             <= RELEASE;
                     timer             <= '0;
                     domain_rst_n_o[0] <= 1'b1;
                  end else begin
                     timer <= timer_nxt;
                  end
               end
               RELEASE: begin
                  if (!locked_s) begin
                     state          <= PLL_RST;
                     timer          <= '0;
                     pll_rst_o      <= 1'b1;
                     domain_rst_n_o <= '0;
                  end else begin
                     timer <= timer_nxt;
                     for (int i = 1; i < N_DOMAINS; i++)
                        if (timer_nxt >= TIMER_W'(i * STAGGER_CYCLES))
                           domain_rst_n_o[i] <= 1'b1;
                     if (timer_nxt == RELEASE_END) begin
                        state       <= RUN;
                        timer       <= '0;
                        retry_cnt_o <= '0;
                     end
                  end
               end
               RUN: begin
                  if (!locked_s) begin
                     state          <= PLL_RST;
                     timer          <= '0;
                     pll_rst_o      <= 1'b1;
                     domain_rst_n_o <= '0;
                  end
               end
               FAIL: begin
                  pll_rst_o      <= 1'b1;
                  domain_rst_n_o <= '0;
               end
               default: begin
                  state          <= PLL_RST;
                  timer          <= '0;
                  pll_rst_o      <= 1'b1;
                  domain_rst_n_o <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scenario bench for pll_lock_supervisor: expected timings come from the
// sequencing rules as plain arithmetic on cycle counts since a known event.
module tb_pll_lock_supervisor;
   import pll_sup_pkg::*;

   localparam int RSTP = 4;
   localparam int TMO  = 100;
   localparam int STB  = 16;
   localparam int STG  = 2;
   localparam int ND   = 4;
   localparam int MR   = 3;
   localparam int PER  = RSTP + TMO;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          pll_locked_i;
   logic          force_relock_i;
   logic          pll_rst_o;
   logic [ND-1:0] domain_rst_n_o;
   logic          ready_o;
   logic          lock_fail_o;
   logic [3:0]    retry_cnt_o;
   logic [7:0]    lock_loss_cnt_o;
   state_t        state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_loss = 0;

   always #5 clk = ~clk;

   pll_lock_supervisor #(
      .N_DOMAINS(ND), .RST_PULSE_CYCLES(RSTP), .LOCK_TIMEOUT_CYCLES(TMO),
      .STABLE_CYCLES(STB), .STAGGER_CYCLES(STG), .MAX_RETRIES(MR)
   ) dut (
      .clk(clk), .reset_n(reset_n), .pll_locked_i(pll_locked_i),
      .force_relock_i(force_relock_i), .pll_rst_o(pll_rst_o),
      .domain_rst_n_o(domain_rst_n_o), .ready_o(ready_o), .lock_fail_o(lock_fail_o),
      .retry_cnt_o(retry_cnt_o), .lock_loss_cnt_o(lock_loss_cnt_o), .state_dbg(state_dbg)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Domain i is released STG*i cycles after domain 0, which releases at cycle rel.
   function automatic logic [ND-1:0] exp_dom(input int c, input int rel);
      logic [ND-1:0] d;
      for (int i = 0; i < ND; i++) d[i] = (c >= rel + i * STG);
      return d;
   endfunction

   // Hold reset for two edges, leave it released with the sample at cycle 0 taken.
   task automatic apply_reset();
      reset_n = 1'b0; pll_locked_i = 1'b0; force_relock_i = 1'b0;
      step(); step();
      reset_n = 1'b1;
      exp_loss = 0;
   endtask

   task automatic wait_ready(input string name, output int n);
      n = 0;
      while (!ready_o && n < 300) begin step(); n++; end
      if (!ready_o) begin
         n_checks++; n_fail++;
         $display("FAIL %s: ready_o never rose within 300 cycles", name);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; pll_locked_i = 1'b1; force_relock_i = 1'b0;
      step(); step();
      n_checks++; if (pll_rst_o !== 1'b1) begin n_fail++; $display("FAIL reset pll_rst got %b exp 1", pll_rst_o); end
      n_checks++; if (domain_rst_n_o !== 4'b0000) begin n_fail++; $display("FAIL reset domains got %b exp 0000", domain_rst_n_o); end
      n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset ready got %b exp 0", ready_o); end
      n_checks++; if (lock_fail_o !== 1'b0) begin n_fail++; $display("FAIL reset lock_fail got %b exp 0", lock_fail_o); end
      n_checks++; if (retry_cnt_o !== 4'd0) begin n_fail++; $display("FAIL reset retry got %0d exp 0", retry_cnt_o); end
      n_checks++; if (lock_loss_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset loss got %0d exp 0", lock_loss_cnt_o); end
   endtask

   task automatic test_nominal();
      int l, rel, rdy;
      l = $urandom_range(4, 40);
      rel = l + 2 + STB;
      rdy = rel + ND * STG;
      apply_reset();
      for (int c = 1; c <= rdy + 3; c++) begin
         step();
         n_checks++; if (pll_rst_o !== (c < RSTP)) begin n_fail++; $display("FAIL nominal pll_rst c=%0d got %b exp %b", c, pll_rst_o, c < RSTP); end
         n_checks++; if (domain_rst_n_o !== exp_dom(c, rel)) begin n_fail++; $display("FAIL nominal domains c=%0d got %b exp %b", c, domain_rst_n_o, exp_dom(c, rel)); end
         n_checks++; if (ready_o !== (c >= rdy)) begin n_fail++; $display("FAIL nominal ready c=%0d got %b exp %b", c, ready_o, c >= rdy); end
         n_checks++; if (retry_cnt_o !== 4'd0) begin n_fail++; $display("FAIL nominal retry c=%0d got %0d exp 0", c, retry_cnt_o); end
         if (c == l) pll_locked_i = 1'b1;
      end
   endtask

   task automatic test_lock_loss();
      int n;
      pll_locked_i = 1'b0;
      step(); step();
      n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL loss early_drop got ready=%b exp 1", ready_o); end
      step();
      exp_loss++;
      n_checks++; if (domain_rst_n_o !== 4'b0000) begin n_fail++; $display("FAIL loss domains got %b exp 0000", domain_rst_n_o); end
      n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL loss ready got %b exp 0", ready_o); end
      n_checks++; if (pll_rst_o !== 1'b1) begin n_fail++; $display("FAIL loss pll_rst got %b exp 1", pll_rst_o); end
      n_checks++; if (lock_loss_cnt_o !== 8'(exp_loss)) begin n_fail++; $display("FAIL loss count got %0d exp %0d", lock_loss_cnt_o, exp_loss); end
      pll_locked_i = 1'b1;
      wait_ready("loss_reseq", n);
      n_checks++; if (n + 3 !== 3 + RSTP + 1 + (STB - 1) + ND * STG) begin n_fail++; $display("FAIL loss reseq_time got %0d exp %0d", n + 3, 3 + RSTP + STB + ND * STG); end
   endtask

   task automatic test_glitch();
      int l, rel, rdy;
      l = $urandom_range(4, 40);
      rel = l + 13 + 2 + STB;
      rdy = rel + ND * STG;
      apply_reset();
      for (int c = 1; c <= rdy + 2; c++) begin
         step();
         n_checks++; if (domain_rst_n_o !== exp_dom(c, rel)) begin n_fail++; $display("FAIL glitch domains c=%0d got %b exp %b", c, domain_rst_n_o, exp_dom(c, rel)); end
         n_checks++; if (ready_o !== (c >= rdy)) begin n_fail++; $display("FAIL glitch ready c=%0d got %b exp %b", c, ready_o, c >= rdy); end
         n_checks++; if (retry_cnt_o !== 4'd0) begin n_fail++; $display("FAIL glitch retry c=%0d got %0d exp 0", c, retry_cnt_o); end
         if (c == l) pll_locked_i = 1'b1;
         if (c == l + 12) pll_locked_i = 1'b0;
         if (c == l + 13) pll_locked_i = 1'b1;
      end
   endtask

   task automatic test_timeout();
      int e_retry;
      logic e_rst, e_fail;
      apply_reset();
      for (int c = 1; c <= MR * PER + 10; c++) begin
         step();
         if (c < MR * PER) begin
            e_rst = ((c % PER) < RSTP); e_retry = c / PER; e_fail = 1'b0;
         end else begin
            e_rst = 1'b1; e_retry = MR; e_fail = 1'b1;
         end
         n_checks++; if (pll_rst_o !== e_rst) begin n_fail++; $display("FAIL timeout pll_rst c=%0d got %b exp %b", c, pll_rst_o, e_rst); end
         n_checks++; if (retry_cnt_o !== 4'(e_retry)) begin n_fail++; $display("FAIL timeout retry c=%0d got %0d exp %0d", c, retry_cnt_o, e_retry); end
         n_checks++; if (lock_fail_o !== e_fail) begin n_fail++; $display("FAIL timeout lock_fail c=%0d got %b exp %b", c, lock_fail_o, e_fail); end
         n_checks++; if (domain_rst_n_o !== 4'b0000 || ready_o !== 1'b0) begin n_fail++; $display("FAIL timeout held c=%0d got dom=%b ready=%b exp 0000/0", c, domain_rst_n_o, ready_o); end
      end
   endtask

   task automatic test_recovery();
      int n;
      pll_locked_i = 1'b1; force_relock_i = 1'b1;
      step();
      force_relock_i = 1'b0;
      n_checks++; if (pll_rst_o !== 1'b1) begin n_fail++; $display("FAIL recovery pll_rst got %b exp 1", pll_rst_o); end
      n_checks++; if (retry_cnt_o !== 4'd0) begin n_fail++; $display("FAIL recovery retry got %0d exp 0", retry_cnt_o); end
      n_checks++; if (lock_fail_o !== 1'b0) begin n_fail++; $display("FAIL recovery lock_fail got %b exp 0", lock_fail_o); end
      wait_ready("recovery", n);
      n_checks++; if (n + 1 !== 1 + RSTP + 1 + (STB - 1) + ND * STG) begin n_fail++; $display("FAIL recovery time got %0d exp %0d", n + 1, 1 + RSTP + STB + ND * STG); end
   endtask

   task automatic test_reset_mid_release();
      int n = 0;
      apply_reset();
      pll_locked_i = 1'b1;
      while (domain_rst_n_o !== 4'b0011 && n < 200) begin step(); n++; end
      n_checks++; if (domain_rst_n_o !== 4'b0011) begin n_fail++; $display("FAIL midrel reach got %b exp 0011", domain_rst_n_o); end
      reset_n = 1'b0;
      step();
      n_checks++; if (domain_rst_n_o !== 4'b0000) begin n_fail++; $display("FAIL midrel domains got %b exp 0000", domain_rst_n_o); end
      n_checks++; if (pll_rst_o !== 1'b1) begin n_fail++; $display("FAIL midrel pll_rst got %b exp 1", pll_rst_o); end
      n_checks++; if (ready_o !== 1'b0 || lock_fail_o !== 1'b0) begin n_fail++; $display("FAIL midrel flags got %b%b exp 00", ready_o, lock_fail_o); end
      n_checks++; if (retry_cnt_o !== 4'd0 || lock_loss_cnt_o !== 8'd0) begin n_fail++; $display("FAIL midrel counters got %0d/%0d exp 0/0", retry_cnt_o, lock_loss_cnt_o); end
      reset_n = 1'b1;
      exp_loss = 0;
   endtask

   task automatic test_back_to_back();
      int n;
      pll_locked_i = 1'b1;
      wait_ready("b2b_run", n);
      pll_locked_i = 1'b0;
      step(); step();
      force_relock_i = 1'b1;
      step();
      force_relock_i = 1'b0;
      exp_loss++;
      n_checks++; if (lock_loss_cnt_o !== 8'(exp_loss)) begin n_fail++; $display("FAIL b2b loss got %0d exp %0d", lock_loss_cnt_o, exp_loss); end
      n_checks++; if (pll_rst_o !== 1'b1 || ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b state got rst=%b ready=%b exp 1/0", pll_rst_o, ready_o); end
      step(); step();
      n_checks++; if (lock_loss_cnt_o !== 8'(exp_loss)) begin n_fail++; $display("FAIL b2b loss_hold got %0d exp %0d", lock_loss_cnt_o, exp_loss); end
   endtask

   task automatic test_saturation();
      int n;
      for (int k = 0; k < 300; k++) begin
         pll_locked_i = 1'b1;
         wait_ready("sat_run", n);
         pll_locked_i = 1'b0;
         step(); step(); step();
         if (exp_loss < 255) exp_loss++;
         if (k == 100 || k == 299) begin
            n_checks++; if (lock_loss_cnt_o !== 8'(exp_loss)) begin n_fail++; $display("FAIL sat count k=%0d got %0d exp %0d", k, lock_loss_cnt_o, exp_loss); end
         end
      end
      n_checks++; if (lock_loss_cnt_o !== 8'd255) begin n_fail++; $display("FAIL sat final got %0d exp 255", lock_loss_cnt_o); end
   endtask

   initial begin
      reset_n = 1'b0; pll_locked_i = 1'b0; force_relock_i = 1'b0;
      test_reset();
      test_nominal();
      test_lock_loss();
      test_glitch();
      test_timeout();
      test_recovery();
      test_reset_mid_release();
      test_back_to_back();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
